// File: rtl/division_pkg.sv
// Shared types and defaults for the restoring-division sequencer.
// The datapath strobes are decoded directly from div_state_t.
package division_pkg;

   localparam int DIV_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      SUB,
      DONE,
      ERROR
   } div_state_t;

endpackage

// File: rtl/division_iter_counter.sv
// Iteration counter for the shift/subtract loop: clears on load and counts
// sub strobes, saturating at WIDTH so it can never wrap.
module division_iter_counter #(
   parameter int WIDTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic incr,
   output logic last_iter
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] count;
   logic          at_limit;

   assign at_limit = (count == CW'(WIDTH));

   // last_iter flags the increment that brings the count to exactly WIDTH,
   // so the FSM can leave SUB on that same edge.
   assign last_iter = incr && (count == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (incr && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/division_controller.sv
// Sequencing front-end for the restoring divider: accepts operands, runs WIDTH
// shift/sub iterations, traps divide-by-zero and holds done until acknowledged.
module division_controller
   import division_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] dividend,
   output logic [WIDTH-1:0] divisor,
   output logic             load,
   output logic             shift,
   output logic             sub,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   input  logic             result_ack
);

   div_state_t state;
   div_state_t state_next;
   logic       accept;
   logic       last_iter;

   assign accept = start_valid && start_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A zero divisor is detected on the incoming operand so the datapath is never loaded.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (divisor_in == '0) ? ERROR : LOAD;
            end
         end
         LOAD:  state_next = SHIFT;
         SHIFT: state_next = SUB;
         SUB:   state_next = last_iter ? DONE : SHIFT;
         DONE, ERROR: begin
            if (result_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      start_ready = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      sub         = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE:  start_ready = 1'b1;
         LOAD:  load        = 1'b1;
         SHIFT: shift       = 1'b1;
         SUB:   sub         = 1'b1;
         DONE:  done        = 1'b1;
         ERROR: begin
            done        = 1'b1;
            div_by_zero = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dividend <= '0;
         divisor  <= '0;
      end else if (accept) begin
         dividend <= dividend_in;
         divisor  <= divisor_in;
      end
   end

   division_iter_counter #(
      .WIDTH(WIDTH)
   ) u_iter_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (load),
      .incr     (sub),
      .last_iter(last_iter)
   );

endmodule

// File: tb/tb_division_controller.sv
// Directed bench for division_controller: a table of operand pairs run through
// a small restoring-division model, plus hand-written multi-cycle sequences.
module tb_division_controller;

   localparam int W = 4;

   localparam logic [6:0] ST_IDLE  = 7'b0000001;
   localparam logic [6:0] ST_LOAD  = 7'b1000010;
   localparam logic [6:0] ST_SHIFT = 7'b0100010;
   localparam logic [6:0] ST_SUB   = 7'b0010010;
   localparam logic [6:0] ST_DONE  = 7'b0001010;
   localparam logic [6:0] ST_ERROR = 7'b0001110;

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   logic         clk;
   logic         reset_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] dividend_in;
   logic [W-1:0] divisor_in;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         load;
   logic         shift;
   logic         sub;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic         result_ack;
   logic [6:0]   status;

   logic [W:0]   rem_m;
   logic [W-1:0] quo_m;

   int total;
   int bad;
   vec_t vectors[8];

   division_controller #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .dividend_in(dividend_in),
      .divisor_in (divisor_in),
      .dividend   (dividend),
      .divisor    (divisor),
      .load       (load),
      .shift      (shift),
      .sub        (sub),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .result_ack (result_ack)
   );

   assign status = {load, shift, sub, done, div_by_zero, busy, start_ready};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Restoring-division datapath driven only by the controller's strobes.
   always @(posedge clk) begin
      if (load) begin
         rem_m <= '0;
         quo_m <= dividend;
      end else if (shift) begin
         {rem_m, quo_m} <= {rem_m[W-1:0], quo_m, 1'b0};
      end else if (sub) begin
         if (rem_m >= {1'b0, divisor}) begin
            rem_m    <= rem_m - {1'b0, divisor};
            quo_m[0] <= 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic valid, input logic [W-1:0] dvd,
                                 input logic [W-1:0] dvs, input logic ack);
      start_valid = valid;
      dividend_in = dvd;
      divisor_in  = dvs;
      result_ack  = ack;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [6:0] expected_status(input int k);
      if (k == 1)               return ST_LOAD;
      else if (k >= 2 && k <= 9) return (k % 2 == 0) ? ST_SHIFT : ST_SUB;
      else                      return ST_DONE;
   endfunction

   task automatic run_vector(input vec_t v);
      apply_stimulus(1'b1, v.dvd, v.dvs, 1'b0);
      check_output("ready_before_accept", 32'(start_ready), 32'd1);
      tick();
      start_valid = 1'b0;
      if (v.dz) begin
         check_output("dz_status", 32'(status), 32'(ST_ERROR));
         check_output("dz_operands", 32'({dividend, divisor}), 32'({v.dvd, v.dvs}));
      end else begin
         for (int k = 1; k <= 2 * W + 2; k++) begin
            dividend_in = 4'($urandom);
            divisor_in  = 4'($urandom);
            check_output($sformatf("status_k%0d", k), 32'(status), 32'(expected_status(k)));
            check_output("operand_hold", 32'({dividend, divisor}), 32'({v.dvd, v.dvs}));
            if (k < 2 * W + 2) tick();
         end
         check_output("quotient", 32'(quo_m), 32'(v.q));
         check_output("remainder", 32'(rem_m), 32'(v.r));
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check_output("idle_after_ack", 32'(status), 32'(ST_IDLE));
   endtask

   initial begin
      int first_load;
      int second_load;
      int load_count;
      bit stable_ok;
      bit done_seen;
      logic [W-1:0] q_first;
      logic [W-1:0] q_second;

      total = 0;
      bad   = 0;
      vectors[0] = '{dvd: 4'd13, dvs: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0};
      vectors[1] = '{dvd: 4'd9,  dvs: 4'd0,  q: 4'd0,  r: 4'd0, dz: 1'b1};
      vectors[2] = '{dvd: 4'd15, dvs: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
      vectors[3] = '{dvd: 4'd6,  dvs: 4'd3,  q: 4'd2,  r: 4'd0, dz: 1'b0};
      vectors[4] = '{dvd: 4'd7,  dvs: 4'd2,  q: 4'd3,  r: 4'd1, dz: 1'b0};
      vectors[5] = '{dvd: 4'd0,  dvs: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
      vectors[6] = '{dvd: 4'd15, dvs: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
      vectors[7] = '{dvd: 4'd14, dvs: 4'd5,  q: 4'd2,  r: 4'd4, dz: 1'b0};

      reset_n = 1'b0;
      apply_stimulus(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      tick();
      check_output("reset_status", 32'(status), 32'(ST_IDLE));
      check_output("reset_operands", 32'({dividend, divisor}), 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_vector(vectors[i]);
      end

      // Backpressure: done held with ack low; a start pulse meanwhile is ignored.
      apply_stimulus(1'b1, 4'd13, 4'd4, 1'b0);
      tick();
      start_valid = 1'b0;
      for (int k = 1; k < 2 * W + 2; k++) tick();
      check_output("bp_done", 32'(status), 32'(ST_DONE));
      for (int j = 0; j < 5; j++) begin
         if (j == 1) apply_stimulus(1'b1, 4'd7, 4'd2, 1'b0);
         if (j == 2) start_valid = 1'b0;
         tick();
         check_output("bp_hold_status", 32'(status), 32'(ST_DONE));
         check_output("bp_hold_operands", 32'({dividend, divisor}), 32'({4'd13, 4'd4}));
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check_output("bp_idle", 32'(status), 32'(ST_IDLE));
      tick();
      check_output("idle_operand_hold", 32'({dividend, divisor}), 32'({4'd13, 4'd4}));

      // Reset during the second SUB cycle discards the run.
      apply_stimulus(1'b1, 4'd7, 4'd2, 1'b0);
      tick();
      start_valid = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      check_output("second_sub", 32'(status), 32'(ST_SUB));
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_output("midrun_reset_status", 32'(status), 32'(ST_IDLE));
      check_output("midrun_reset_operands", 32'({dividend, divisor}), 32'd0);
      done_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      check_output("no_done_after_reset", 32'(done_seen), 32'd0);

      // Back-to-back with ack tied high and start_valid held.
      apply_stimulus(1'b1, 4'd15, 4'd1, 1'b1);
      first_load  = -1;
      second_load = -1;
      load_count  = 0;
      stable_ok   = 1'b1;
      q_first     = '0;
      q_second    = '0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (load) begin
            load_count++;
            if (load_count == 1) begin
               first_load  = c;
               dividend_in = 4'd6;
               divisor_in  = 4'd3;
            end else if (load_count == 2) begin
               second_load = c;
               start_valid = 1'b0;
               check_output("b2b_second_operands", 32'({dividend, divisor}), 32'({4'd6, 4'd3}));
            end
         end else if (load_count == 1 && {dividend, divisor} !== {4'd15, 4'd1}) begin
            stable_ok = 1'b0;
         end
         if (done && load_count == 1) q_first = quo_m;
         if (done && load_count == 2) q_second = quo_m;
      end
      result_ack = 1'b0;
      check_output("b2b_interval", 32'(second_load - first_load), 32'd11);
      check_output("b2b_operand_stable", 32'(stable_ok), 32'd1);
      check_output("b2b_first_quotient", 32'(q_first), 32'd15);
      check_output("b2b_second_quotient", 32'(q_second), 32'd2);
      check_output("b2b_final_idle", 32'(status), 32'(ST_IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
